// File: rtl/div_ctrl.sv
// DIV/IDIV front/back end for the 80188-class execution unit: forms operands, screens
// divide-by-zero and quotient overflow, runs the toggle handshake and fixes up the signs.
module div_ctrl #(
  parameter bit ALLOW_MIN_QUOT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op_signed,
  input  logic        op_word,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [15:0] quot,
  output logic [15:0] rem,
  output logic [31:0] div_dividend,
  output logic [15:0] div_divisor,
  output logic        div_signed,
  output logic        div_run,
  input  logic        div_done,
  input  logic [15:0] div_q,
  input  logic [15:0] div_r
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT,
    S_FIX,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic        signed_q, signed_d;
  logic        word_q, word_d;
  logic        quot_neg_q, quot_neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic [31:0] dvd_q, dvd_d;
  logic [15:0] dvs_q, dvs_d;
  logic        run_q, run_d;
  logic        fault_q, fault_d;
  logic [15:0] quot_q, quot_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] qraw_q, qraw_d;
  logic [15:0] rraw_q, rraw_d;

  logic [31:0] ext_dvd;
  logic [15:0] ext_dvs;
  logic [31:0] mag_dvd;
  logic [15:0] mag_dvs;
  logic        chk_fault;
  logic        ack_match;
  logic [15:0] q_mag;
  logic [15:0] r_mag;
  logic [15:0] rem_fix;
  logic        rng_fault;

  // ---------------------------------------------------------------------------
  // Operand forming and fault screening
  // ---------------------------------------------------------------------------
  always_comb begin
    if (op_word) begin
      ext_dvd = dividend;
      ext_dvs = divisor;
    end else if (op_signed) begin
      ext_dvd = {{16{dividend[15]}}, dividend[15:0]};
      ext_dvs = {{8{divisor[7]}}, divisor[7:0]};
    end else begin
      ext_dvd = {16'h0000, dividend[15:0]};
      ext_dvs = {8'h00, divisor[7:0]};
    end

    // Operands are already sign-extended, so bit 31/15 is the sign at either width.
    mag_dvd = (signed_q && dvd_q[31]) ? (~dvd_q + 32'd1) : dvd_q;
    mag_dvs = (signed_q && dvs_q[15]) ? (~dvs_q + 16'd1) : dvs_q;

    chk_fault = (dvs_q == 16'h0000) ||
                (word_q ? (mag_dvd[31:16] >= mag_dvs)
                        : (mag_dvd[15:8] >= mag_dvs[7:0]));

    ack_match = (div_done == run_q);

    q_mag   = quot_neg_q ? (~qraw_q + 16'd1) : qraw_q;
    r_mag   = quot_neg_q ? (~rraw_q + 16'd1) : rraw_q;
    rem_fix = rem_neg_q ? (~r_mag + 16'd1) : r_mag;

    rng_fault = 1'b0;
    if (signed_q) begin
      if (word_q) begin
        rng_fault = quot_neg_q ? ((q_mag > 16'h8000) || ((q_mag == 16'h8000) && !ALLOW_MIN_QUOT))
                               : (q_mag > 16'h7FFF);
      end else begin
        rng_fault = quot_neg_q ? ((q_mag[7:0] > 8'h80) || ((q_mag[7:0] == 8'h80) && !ALLOW_MIN_QUOT))
                               : (q_mag[7:0] > 8'h7F);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_CHECK;
      S_CHECK: state_d = chk_fault ? S_DONE : S_WAIT;
      S_WAIT:  if (ack_match) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy  = (state_q == S_CHECK) || (state_q == S_WAIT) || (state_q == S_FIX);
    done  = (state_q == S_DONE);
    fault = (state_q == S_DONE) && fault_q;
  end

  assign quot         = quot_q;
  assign rem          = rem_q;
  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;
  assign div_signed   = signed_q;
  assign div_run      = run_q;

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a hold default first, so no path through the case infers a latch.
  always_comb begin
    signed_d   = signed_q;
    word_d     = word_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    run_d      = run_q;
    fault_d    = fault_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    qraw_d     = qraw_q;
    rraw_d     = rraw_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          signed_d   = op_signed;
          word_d     = op_word;
          dvd_d      = ext_dvd;
          dvs_d      = ext_dvs;
          quot_neg_d = op_signed & (ext_dvd[31] ^ ext_dvs[15]);
          rem_neg_d  = op_signed & ext_dvd[31];
          fault_d    = 1'b0;
        end
      end
      S_CHECK: begin
        fault_d = chk_fault;
        if (!chk_fault) run_d = ~run_q;
      end
      S_WAIT: begin
        // The divider only guarantees its result in the acknowledge cycle.
        if (ack_match) begin
          qraw_d = div_q;
          rraw_d = div_r;
        end
      end
      S_FIX: begin
        fault_d = rng_fault;
        if (!rng_fault) begin
          quot_d = word_q ? qraw_q  : {8'h00, qraw_q[7:0]};
          rem_d  = word_q ? rem_fix : {8'h00, rem_fix[7:0]};
        end
      end
      default: ;
    endcase
  end

  // Reset re-aligns div_run with the divider acknowledge, abandoning any divide in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      signed_q   <= 1'b0;
      word_q     <= 1'b0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      dvd_q      <= 32'h0;
      dvs_q      <= 16'h0;
      run_q      <= div_done;
      fault_q    <= 1'b0;
      quot_q     <= 16'h0;
      rem_q      <= 16'h0;
      qraw_q     <= 16'h0;
      rraw_q     <= 16'h0;
    end else begin
      signed_q   <= signed_d;
      word_q     <= word_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      run_q      <= run_d;
      fault_q    <= fault_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      qraw_q     <= qraw_d;
      rraw_q     <= rraw_d;
    end
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Execution-unit front/back end for DIV/IDIV (byte and word forms) on the 80188-class core.
- Sits between operand fetch/writeback and the 16-cycle radix-2 divider core. It forms operands, rejects divide-by-zero and quotient overflow (vector 0), and drives the divider's toggle handshake.
- It post-corrects results to x86 semantics: remainder takes the dividend's sign.

Parameters:
- ALLOW_MIN_QUOT, 1, 1 = signed quotient -128 / -32768 accepted (80186+); 0 = faults (8086).

Ports:
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; ignored while busy=1
- op_signed  in  1  1 = IDIV, 0 = DIV
- op_word  in  1  1 = DX:AX / r16, 0 = AX / r8
- dividend  in  32  DX:AX; byte op uses [15:0] only
- divisor  in  16  byte op uses [7:0] only
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse
- fault  out  1  valid with done; 1 = divide error, quot/rem unchanged
- quot  out  16  quotient; byte op: AL in [7:0], [15:8]=0
- rem  out  16  remainder; byte op: AH in [7:0], [15:8]=0
- div_dividend  out  32  to divider, sign-extended to 32 when op_signed
- div_divisor  out  16  to divider, sign-extended to 16 when op_signed
- div_signed  out  1  to divider
- div_run  out  1  toggle request to divider
- div_done  in  1  divider toggle acknowledge; result valid when div_done==div_run
- div_q  in  16  divider quotient, sign-applied by divider
- div_r  in  16  divider remainder, divider negates it when quotient sign is negative

Behaviour:
- Reset values: busy=0, done=0, fault=0, quot=0, rem=0, div_signed=0, div_dividend=0, div_divisor=0, state=IDLE.
- On reset, div_run<=div_done. This resynchronises the handshake and aborts any in-flight divide. It takes priority over every other event, including mid-WAIT.
- IDLE:
  - On start, latch op_signed, op_word and the sign-extended operands into div_* registers.
  - Compute magnitudes: |D| (32 b unsigned) and |d| (16 b unsigned; -32768 becomes 0x8000).
  - Record neg_q = op_signed & (sD ^ sd) and neg_r = op_signed & sD, where sD and sd are the operand sign bits of the active width.
  - Go to CHECK.
- CHECK (1 cycle):
  - Fault if d==0 (active width).
  - Word: fault if |D|[31:16] >= |d|. Byte: fault if |D|[15:8] >= |d|[7:0]. Unsigned ops use raw values.
  - On fault go to DONE with fault=1; div_run is not toggled.
  - Otherwise div_run<=~div_run and go to WAIT.
- WAIT: hold until div_done==div_run. div_q and div_r are sampled only in that cycle; go to FIX.
- FIX:
  - Q = neg_q ? -div_q : div_q (magnitude).
  - Rm = neg_q ? -div_r : div_r (magnitude).
  - Signed range check: word positive fault if Q>0x7FFF; word negative fault if Q>0x8000, or Q==0x8000 with ALLOW_MIN_QUOT=0. Byte uses 0x7F/0x80 on Q[7:0] (Q[15:8] is guaranteed 0 by CHECK).
  - If no fault: quot<=div_q (width-masked); rem<=neg_r ? -Rm : Rm (width-masked). Go to DONE.
- DONE: done=1 and fault valid for exactly one cycle; busy=0 in this cycle; go to IDLE.
  - A start in the DONE cycle is ignored.
  - A start in the following IDLE cycle is accepted.
- Latency, counting the start cycle as 0:
  - Fault in CHECK: done in cycle 2.
  - Otherwise: done in cycle L+4, where L = divider toggle-to-acknowledge latency (17 for the current core, giving done in cycle 21).
- quot and rem hold their last successful values until the next successful op.
- fault is 0 whenever done=0.

Test Plan:
- Unsigned word, 0x00010000 / 0x0003 -> done cycle 21, fault=0, quot=0x5555, rem=0x0001; div_run toggled once.
- Divisor 0 (word and byte), start -> done in cycle 2, fault=1, div_run unchanged, quot/rem unchanged.
- Unsigned pre-overflow, 0x00050000 / 0x0005 -> fault=1 in cycle 2. Byte AX=0x0500 / 0x05 -> fault=1.
- Signed remainder fixup:
  - 7 / -2 (word) -> quot=0xFFFD, rem=0x0001.
  - -7 / 2 -> quot=0xFFFD, rem=0xFFFF.
  - Byte AX=0xFFF9 / 0xFE -> quot=0x0003, rem=0x00FF.
- Signed boundary:
  - 0x00008000 / 1 -> fault=1 from FIX.
  - 0xFFFF8000 / 1 -> quot=0x8000, rem=0, fault=0; with ALLOW_MIN_QUOT=0 -> fault=1.
  - Byte AX=0xFF80 / 0x01 -> quot=0x0080.
- Assert reset in the 5th WAIT cycle -> next cycle busy=0, no done pulse, div_run==div_done. A following 100/7 unsigned op -> quot=14, rem=2.
